// File: rtl/fifo_wptr_gray.sv
// Write-side pointer and status generator for a dual-clock FIFO.
// Keeps the binary write pointer and publishes a registered Gray pointer for the read-domain synchronizer.
module fifo_wptr_gray #(
  parameter int ADDR_WIDTH = 4,
  parameter int AFULL_THR  = 2**ADDR_WIDTH - 2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  wr_en_i,
  input  logic [ADDR_WIDTH:0]   rptr_gray_i,
  output logic                  wr_ack_o,
  output logic [ADDR_WIDTH-1:0] waddr_o,
  output logic [ADDR_WIDTH:0]   wptr_gray_o,
  output logic                  full_o,
  output logic                  afull_o,
  output logic [ADDR_WIDTH:0]   wcount_o,
  output logic                  ovf_o
);

  localparam int PW = ADDR_WIDTH + 1;
  // Full when the write Gray pointer equals the read Gray pointer with its top two bits inverted;
  // with ADDR_WIDTH=1 the mask covers both pointer bits.
  localparam logic [PW-1:0] FULL_MASK   = PW'(3) << (ADDR_WIDTH - 1);
  localparam logic [PW-1:0] AFULL_THR_W = PW'(AFULL_THR);

  logic [PW-1:0] wbin_q, wbin_d;
  logic [PW-1:0] wgray_q, wgray_d;
  logic [PW-1:0] wcount_q, wcount_d;
  logic [PW-1:0] rbin;
  logic          full_q, full_d;
  logic          afull_q, afull_d;
  logic          ovf_q, ovf_d;

  always_comb begin
    rbin = '0;
    rbin[PW-1] = rptr_gray_i[PW-1];
    for (int i = PW - 2; i >= 0; i--) begin
      rbin[i] = rbin[i+1] ^ rptr_gray_i[i];
    end
  end

  // NOTE: every variable gets a value before any branch so no latch is inferred.
  always_comb begin
    wr_ack_o = wr_en_i & ~full_q;
    wbin_d   = wbin_q + PW'(wr_ack_o);
    wgray_d  = wbin_d ^ (wbin_d >> 1);
    full_d   = (wgray_d == (rptr_gray_i ^ FULL_MASK));
    wcount_d = wbin_d - rbin;
    afull_d  = (wcount_d >= AFULL_THR_W);
    ovf_d    = ovf_q | (wr_en_i & full_q);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wbin_q   <= '0;
      wgray_q  <= '0;
      full_q   <= 1'b0;
      afull_q  <= 1'b0;
      wcount_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wbin_q   <= wbin_d;
      wgray_q  <= wgray_d;
      full_q   <= full_d;
      afull_q  <= afull_d;
      wcount_q <= wcount_d;
      ovf_q    <= ovf_d;
    end
  end

  assign waddr_o     = wbin_q[ADDR_WIDTH-1:0];
  assign wptr_gray_o = wgray_q;
  assign full_o      = full_q;
  assign afull_o     = afull_q;
  assign wcount_o    = wcount_q;
  assign ovf_o       = ovf_q;

endmodule
